// File: rtl/mmu_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : mmu_dispatcher
// Description : Streams operand pairs to a pipelined multiply unit and
//               accumulates the returned product-sums into one result.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_dispatcher #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [7:0]  cmd_len,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [7:0]  mmu_opcode,
    output logic [31:0] mmu_a,
    output logic [31:0] mmu_b,
    input  logic [31:0] mmu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [7:0]  res_count,
    output logic        res_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [7:0] c_OP_DOT16 = 8'h03;
    localparam logic [7:0] c_OP_DOT8  = 8'h04;
    localparam logic [7:0] c_OP_BUBBLE = 8'h00;

    logic [1:0]       r_state;
    logic [7:0]       r_opcode;
    logic [7:0]       r_len;
    logic [7:0]       r_issued;
    logic [LATENCY:0] r_vld;

    logic w_cmd_fire;
    logic w_op_fire;
    logic w_res_fire;
    logic w_acc_en;
    logic w_illegal;

    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_op_fire  = op_valid & op_ready;
    assign w_res_fire = res_valid & res_ready;
    // r_vld[LATENCY] marks the cycle in which mmu_result belongs to an issued pair
    assign w_acc_en   = r_vld[LATENCY];
    assign w_illegal  = (cmd_opcode != c_OP_DOT16) && (cmd_opcode != c_OP_DOT8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_opcode   <= c_OP_BUBBLE;
            r_len      <= 8'd0;
            r_issued   <= 8'd0;
            r_vld      <= '0;
            cmd_ready  <= 1'b1;
            op_ready   <= 1'b0;
            mmu_opcode <= c_OP_BUBBLE;
            mmu_a      <= 32'd0;
            mmu_b      <= 32'd0;
            res_valid  <= 1'b0;
            res_data   <= 32'd0;
            res_count  <= 8'd0;
            res_err    <= 1'b0;
        end else begin
            r_vld      <= {r_vld[LATENCY-1:0], w_op_fire};
            mmu_opcode <= c_OP_BUBBLE;

            if (w_op_fire) begin
                mmu_a      <= op_a;
                mmu_b      <= op_b;
                mmu_opcode <= r_opcode;
                r_issued   <= r_issued + 8'd1;
            end

            if (w_acc_en) begin
                res_data  <= res_data + mmu_result;
                res_count <= res_count + 8'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_cmd_fire) begin
                        r_opcode  <= cmd_opcode;
                        r_len     <= cmd_len;
                        r_issued  <= 8'd0;
                        r_vld     <= '0;
                        res_data  <= 32'd0;
                        res_count <= 8'd0;
                        cmd_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state   <= c_DONE;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                        end else if (cmd_len == 8'd0) begin
                            r_state   <= c_DONE;
                            res_valid <= 1'b1;
                            res_err   <= 1'b0;
                        end else begin
                            r_state  <= c_ISSUE;
                            op_ready <= 1'b1;
                            res_err  <= 1'b0;
                        end
                    end
                end
                c_ISSUE: begin
                    if (w_op_fire && (r_issued + 8'd1 == r_len)) begin
                        op_ready <= 1'b0;
                        r_state  <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_acc_en && (res_count + 8'd1 == r_len)) begin
                        r_state   <= c_DONE;
                        res_valid <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (w_res_fire) begin
                        r_state   <= c_IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
